// File: rtl/noc_tx_arbiter_pkg.sv
// Shared NoC transmit-arbiter types and constants.
package noc_tx_arbiter_pkg;

   typedef enum logic {
      StArb  = 1'b0,
      StXfer = 1'b1
   } arb_state_e;

   localparam int unsigned BeatCntW        = 8;
   localparam int unsigned MaxBeatsDefault = 64;
   localparam int unsigned PktCntW         = 16;

endpackage

// File: rtl/noc_tx_arbiter_rr_pick.sv
// Rotate-priority first-one search: first set request at or above the pointer, wrapping.
module noc_tx_arbiter_rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [IdxW-1:0] i_ptr,
   output logic [IdxW-1:0] o_idx,
   output logic            o_any
);

   logic            w_found;
   logic [IdxW-1:0] w_cand;

   always_comb begin
      o_idx   = '0;
      o_any   = |i_req;
      w_found = 1'b0;
      w_cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = IdxW'((32'(i_ptr) + k) % N);
         if (!w_found && i_req[w_cand]) begin
            o_idx   = w_cand;
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Packet-level round-robin arbiter merging N_REQ AXI-stream sources onto one NoC stream.
module noc_tx_arbiter
   import noc_tx_arbiter_pkg::*;
#(
   parameter int unsigned BW        = 32,
   parameter int unsigned BWB       = BW / 8,
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BEATS = MaxBeatsDefault
) (
   input  logic                       clk_line,
   input  logic                       clk_line_rst_low,
   input  logic [N_REQ-1:0]           req_TVALID,
   input  logic [N_REQ*BW-1:0]        req_TDATA,
   input  logic [N_REQ*BWB-1:0]       req_TKEEP,
   input  logic [N_REQ-1:0]           req_TLAST,
   output logic [N_REQ-1:0]           req_TREADY,
   input  logic                       stream_out_TREADY,
   output logic                       stream_out_TVALID,
   output logic [BW-1:0]              stream_out_TDATA,
   output logic [BWB-1:0]             stream_out_TKEEP,
   output logic                       stream_out_TLAST,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic [PktCntW-1:0]         pkt_count,
   output logic                       err_overlen,
   input  logic                       err_clr
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   arb_state_e          r_state, w_state_d;
   logic [IdxW-1:0]     r_grant, r_rr_ptr, w_pick_idx;
   logic                w_pick_any;
   logic [BeatCntW-1:0] r_beat_cnt;
   logic [PktCntW-1:0]  r_pkt_count;
   logic                r_err;
   logic                w_sel_valid, w_sel_last, w_accept, w_last_acc, w_err_set;

   noc_tx_arbiter_rr_pick #(
      .N    (N_REQ),
      .IdxW (IdxW)
   ) u_rr_pick (
      .i_req (req_TVALID),
      .i_ptr (r_rr_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   assign w_sel_valid = req_TVALID[r_grant];
   assign w_sel_last  = req_TLAST[r_grant];
   assign w_accept    = (r_state == StXfer) && w_sel_valid && stream_out_TREADY;
   assign w_last_acc  = w_accept && w_sel_last;
   // Flag the beat that takes the non-last count up to MAX_BEATS.
   assign w_err_set   = w_accept && !w_sel_last && ((32'(r_beat_cnt) + 1) == MAX_BEATS);

   always_comb begin
      w_state_d         = r_state;
      req_TREADY        = '0;
      stream_out_TVALID = 1'b0;
      stream_out_TDATA  = '0;
      stream_out_TKEEP  = '0;
      stream_out_TLAST  = 1'b0;
      unique case (r_state)
         StArb: begin
            if (w_pick_any) w_state_d = StXfer;
         end
         StXfer: begin
            req_TREADY[r_grant] = stream_out_TREADY;
            stream_out_TVALID   = w_sel_valid;
            if (w_sel_valid) begin
               stream_out_TDATA = req_TDATA[32'(r_grant) * BW +: BW];
               stream_out_TKEEP = req_TKEEP[32'(r_grant) * BWB +: BWB];
               stream_out_TLAST = w_sel_last;
            end
            if (w_last_acc) w_state_d = StArb;
         end
      endcase
   end

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) begin
         r_state     <= StArb;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_pkt_count <= '0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StArb && w_pick_any) r_grant <= w_pick_idx;
         if (w_last_acc) begin
            r_rr_ptr    <= (32'(r_grant) == N_REQ - 1) ? '0 : r_grant + 1'b1;
            r_pkt_count <= r_pkt_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) begin
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == StArb) begin
            r_beat_cnt <= '0;
         end else if (w_accept && !w_sel_last && r_beat_cnt != '1) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign busy        = (r_state == StXfer);
   assign grant_id    = r_grant;
   assign pkt_count   = r_pkt_count;
   assign err_overlen = r_err;

endmodule
